// File: rtl/spi_pkg.sv
// Shared SPI definitions: default shift-register width and the
// transaction FSM state encoding, plus a small state helper.
package spi_pkg;

  localparam int SPI_WIDTH = 8;

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_GET_ADDR    = 3'd1;
  localparam logic [2:0] S_GOT_ADDR    = 3'd2;
  localparam logic [2:0] S_READ_LOAD   = 3'd3;
  localparam logic [2:0] S_READ_SHIFT  = 3'd4;
  localparam logic [2:0] S_WRITE_SHIFT = 3'd5;
  localparam logic [2:0] S_WRITE_MEM   = 3'd6;
  localparam logic [2:0] S_DONE        = 3'd7;

  // A CS release in these states cuts a transaction short.
  function automatic logic abortable(input logic [2:0] s);
    return (s != S_IDLE) && (s != S_DONE);
  endfunction

endpackage

// File: rtl/spi_bitcounter.sv
// SPI bit counter: counts SCLK edges, saturates at WIDTH.
// Ports: clk, reset (sync, high), clear, inc, done (WIDTH-th edge).
module spi_bitcounter
  import spi_pkg::*;
#(
  parameter int WIDTH = SPI_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  logic [CW-1:0] count;

  // done marks the edge that brings the count to WIDTH
  assign done = inc && (count == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != FULL)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/spi_fsm.sv
// SPI peripheral transaction FSM with registered Moore enables.
// Ports: clk, reset, sclkPosEdge, chipSelect (low), shiftRegOut,
// srWrEn, addrLatchEn, dataMemWrEn, misoBufEn, txnAbort.
// SPI_FSM_ABORT_EN enables the txnAbort pulse; otherwise it is 0.
module spi_fsm
  import spi_pkg::*;
#(
  parameter int WIDTH = SPI_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclkPosEdge,
  input  logic             chipSelect,
  input  logic [WIDTH-1:0] shiftRegOut,
  output logic             srWrEn,
  output logic             addrLatchEn,
  output logic             dataMemWrEn,
  output logic             misoBufEn,
  output logic             txnAbort
);

  logic [2:0] state;
  logic [2:0] nxt;
  logic       counting;
  logic       cnt_done;
  logic       unused_sr;

  // only the R/W bit of the shifted address matters here
  assign unused_sr = ^shiftRegOut[WIDTH-1:1];

  assign counting = (state == S_GET_ADDR)
                 || (state == S_READ_SHIFT)
                 || (state == S_WRITE_SHIFT);

  spi_bitcounter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk  (clk),
    .reset(reset),
    .clear(!counting),
    .inc  (sclkPosEdge && counting),
    .done (cnt_done)
  );

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:
        if (!chipSelect) nxt = S_GET_ADDR;
      S_GET_ADDR:
        if (cnt_done) nxt = S_GOT_ADDR;
      S_GOT_ADDR:
        nxt = shiftRegOut[0] ? S_READ_LOAD
                             : S_WRITE_SHIFT;
      S_READ_LOAD:
        nxt = S_READ_SHIFT;
      S_READ_SHIFT:
        if (cnt_done) nxt = S_DONE;
      S_WRITE_SHIFT:
        if (cnt_done) nxt = S_WRITE_MEM;
      S_WRITE_MEM:
        nxt = S_DONE;
      S_DONE:
        nxt = S_DONE;
      default:
        nxt = S_IDLE;
    endcase
    // CS release beats any pending edge or transition
    if (chipSelect && (state != S_IDLE)) nxt = S_IDLE;
  end

  // enables are decoded from the next state so they are
  // registered yet line up with the state they belong to
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      srWrEn      <= 1'b0;
      addrLatchEn <= 1'b0;
      dataMemWrEn <= 1'b0;
      misoBufEn   <= 1'b0;
    end else begin
      state       <= nxt;
      srWrEn      <= (nxt == S_READ_LOAD);
      addrLatchEn <= (nxt == S_GOT_ADDR);
      dataMemWrEn <= (nxt == S_WRITE_MEM);
      misoBufEn   <= (nxt == S_READ_SHIFT);
    end
  end

`ifdef SPI_FSM_ABORT_EN
  logic abort_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      abort_q <= 1'b0;
    end else begin
      abort_q <= chipSelect && abortable(state);
    end
  end

  assign txnAbort = abort_q;
`else
  assign txnAbort = 1'b0;
`endif

endmodule

// File: tb/tb_spi_fsm.sv
// Self-checking bench for spi_fsm: directed scenarios plus
// randomized transactions against a transaction-level model.
module tb_spi_fsm;

  localparam int W = 8;

`ifdef SPI_FSM_ABORT_EN
  localparam logic [4:0] AB = 5'b00001;
`else
  localparam logic [4:0] AB = 5'b00000;
`endif
  // expected vector order: {srWrEn, addrLatchEn, dataMemWrEn, misoBufEn, txnAbort}
  localparam logic [4:0] Z  = 5'b00000;
  localparam logic [4:0] SR = 5'b10000;
  localparam logic [4:0] AL = 5'b01000;
  localparam logic [4:0] DM = 5'b00100;
  localparam logic [4:0] MI = 5'b00010;

  logic         clk = 1'b0;
  logic         reset;
  logic         sclkPosEdge;
  logic         chipSelect;
  logic [W-1:0] shiftRegOut;
  logic         srWrEn;
  logic         addrLatchEn;
  logic         dataMemWrEn;
  logic         misoBufEn;
  logic         txnAbort;

  int errors = 0;
  int checks = 0;

  spi_fsm #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .sclkPosEdge(sclkPosEdge),
    .chipSelect (chipSelect),
    .shiftRegOut(shiftRegOut),
    .srWrEn     (srWrEn),
    .addrLatchEn(addrLatchEn),
    .dataMemWrEn(dataMemWrEn),
    .misoBufEn  (misoBufEn),
    .txnAbort   (txnAbort)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] outs();
    return {srWrEn, addrLatchEn, dataMemWrEn, misoBufEn, txnAbort};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction model: what each phase of a CS-low transfer must
  // show, derived from the address R/W bit. abort_at picks the
  // edge index (0..15) replaced by a CS release; -1 means none.
  task automatic run_txn(input logic [W-1:0] addr,
                         input int abort_at,
                         input int max_gap,
                         input string tag);
    logic         rd;
    logic [W-1:0] sr;
    logic [4:0]   ph;
    rd = addr[0];
    sr = '0;
    chipSelect = 1'b0;
    tick();
    checks++;
    if (outs() !== Z) begin
      errors++;
      $display("FAIL %s start: got %b want %b", tag, outs(), Z);
    end
    for (int i = 0; i < 2 * W; i++) begin
      ph = (i >= W && rd) ? MI : Z;
      if (i == W) begin
        tick();
        checks++;
        if (outs() !== (rd ? SR : Z)) begin
          errors++;
          $display("FAIL %s load: got %b want %b", tag, outs(), rd ? SR : Z);
        end
        if (rd) begin
          tick();
          checks++;
          if (outs() !== MI) begin
            errors++;
            $display("FAIL %s rshift: got %b want %b", tag, outs(), MI);
          end
        end
      end
      if (i == abort_at) begin
        chipSelect = 1'b1;
        tick();
        checks++;
        if (outs() !== AB) begin
          errors++;
          $display("FAIL %s abort: got %b want %b", tag, outs(), AB);
        end
        tick();
        checks++;
        if (outs() !== Z) begin
          errors++;
          $display("FAIL %s post-abort: got %b want %b", tag, outs(), Z);
        end
        return;
      end
      repeat ($urandom_range(max_gap)) begin
        tick();
        checks++;
        if (outs() !== ph) begin
          errors++;
          $display("FAIL %s gap%0d: got %b want %b", tag, i, outs(), ph);
        end
      end
      sclkPosEdge = 1'b1;
      if (i < W) sr = {sr[W-2:0], addr[W-1-i]};
      shiftRegOut = sr;
      tick();
      sclkPosEdge = 1'b0;
      if (i == W - 1) ph = AL;
      if (i == 2 * W - 1) ph = rd ? Z : DM;
      checks++;
      if (outs() !== ph) begin
        errors++;
        $display("FAIL %s edge%0d: got %b want %b", tag, i, outs(), ph);
      end
    end
    if (!rd) begin
      tick();
      checks++;
      if (outs() !== Z) begin
        errors++;
        $display("FAIL %s wr-done: got %b want %b", tag, outs(), Z);
      end
    end
    // stray edge in DONE changes nothing
    sclkPosEdge = 1'b1;
    tick();
    sclkPosEdge = 1'b0;
    tick();
    checks++;
    if (outs() !== Z) begin
      errors++;
      $display("FAIL %s done-edge: got %b want %b", tag, outs(), Z);
    end
    chipSelect = 1'b1;
    tick();
    checks++;
    if (outs() !== Z) begin
      errors++;
      $display("FAIL %s release: got %b want %b", tag, outs(), Z);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    chipSelect = 1'b0;
    sclkPosEdge = 1'b1;
    shiftRegOut = '1;
    tick();
    tick();
    checks++;
    if (outs() !== Z) begin
      errors++;
      $display("FAIL reset: got %b want %b", outs(), Z);
    end
    reset = 1'b0;
    chipSelect = 1'b1;
    tick();
    sclkPosEdge = 1'b0;
    tick();
    checks++;
    if (outs() !== Z) begin
      errors++;
      $display("FAIL idle_edge: got %b want %b", outs(), Z);
    end
  endtask

  task automatic test_read();
    run_txn(8'b1010_1011, -1, 0, "read");
    run_txn(8'b1010_1011, -1, 3, "read_gap");
  endtask

  task automatic test_write();
    run_txn(8'b0101_0100, -1, 0, "write");
    run_txn(8'b0101_0100, -1, 3, "write_gap");
  endtask

  task automatic test_abort();
    run_txn(8'b1010_1011, 3, 1, "abort_addr");
    run_txn(8'b1010_1011, 11, 1, "abort_read");
    run_txn(8'b0101_0100, 13, 1, "abort_write");
  endtask

  task automatic test_reset_mid();
    chipSelect = 1'b0;
    tick();
    for (int i = 0; i < W + 4; i++) begin
      if (i == W) tick();
      if (i == W) tick();
      sclkPosEdge = 1'b1;
      shiftRegOut = 8'b1010_1011;
      tick();
      sclkPosEdge = 1'b0;
    end
    checks++;
    if (outs() !== MI) begin
      errors++;
      $display("FAIL rmid_pre: got %b want %b", outs(), MI);
    end
    reset = 1'b1;
    sclkPosEdge = 1'b1;
    tick();
    reset = 1'b0;
    sclkPosEdge = 1'b0;
    checks++;
    if (outs() !== Z) begin
      errors++;
      $display("FAIL rmid_reset: got %b want %b", outs(), Z);
    end
    run_txn(8'b1010_1011, -1, 1, "rmid_fresh");
  endtask

  task automatic test_cs_race();
    logic [4:0] seen;
    chipSelect = 1'b0;
    tick();
    for (int i = 0; i < W - 1; i++) begin
      sclkPosEdge = 1'b1;
      tick();
      sclkPosEdge = 1'b0;
    end
    sclkPosEdge = 1'b1;
    chipSelect = 1'b1;
    tick();
    sclkPosEdge = 1'b0;
    checks++;
    if (outs() !== AB) begin
      errors++;
      $display("FAIL race: got %b want %b", outs(), AB);
    end
    seen = '0;
    repeat (3) begin
      tick();
      seen |= outs();
    end
    checks++;
    if (seen !== Z) begin
      errors++;
      $display("FAIL race_after: got %b want %b", seen, Z);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    int ab;
    for (int n = 0; n < 30; n++) begin
      a = W'($urandom);
      ab = ($urandom_range(3) == 0) ? int'($urandom_range(2 * W - 1)) : -1;
      run_txn(a, ab, 3, "rand");
      repeat ($urandom_range(2)) tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    chipSelect = 1'b1;
    sclkPosEdge = 1'b0;
    shiftRegOut = '0;
    test_reset();
    test_read();
    test_write();
    test_abort();
    test_reset_mid();
    test_cs_race();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_fsm.md
SPI_FSM -- requirements
Module: spi_fsm

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning shift-register width in bits (address field = WIDTH-1 bits + 1 R/W bit).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port sclkPosEdge  input  1  one-clk pulse per conditioned SCLK rising edge (same pulse that drives the shift register's peripheralClkEdge).
REQ-005 SHALL have port chipSelect  input  1  conditioned CS, active-low.
REQ-006 SHALL have port shiftRegOut  input  WIDTH  shift register parallelDataOut.
REQ-007 SHALL have port srWrEn  output  1  drives shift register parallelLoad.
REQ-008 SHALL have port addrLatchEn  output  1  address latch enable.
REQ-009 SHALL have port dataMemWrEn  output  1  data memory write enable.
REQ-010 SHALL have port misoBufEn  output  1  MISO tri-state buffer enable.
REQ-011 SHALL have port txnAbort  output  1  one-clk pulse on CS deassert mid-transaction.

Function
REQ-012 SHALL implement states IDLE, GET_ADDR, GOT_ADDR, READ_LOAD, READ_SHIFT, WRITE_SHIFT, WRITE_MEM, DONE.
REQ-013 IDLE: chipSelect=0 -> GET_ADDR next clk; bit counter cleared to 0.
REQ-014 GET_ADDR: counter increments on each sclkPosEdge; on the WIDTH-th edge -> GOT_ADDR next clk.
REQ-015 GOT_ADDR: addrLatchEn=1 for exactly one clk; shiftRegOut[0]=1 -> READ_LOAD, =0 -> WRITE_SHIFT; counter cleared.
REQ-016 READ_LOAD: srWrEn=1 for exactly one clk -> READ_SHIFT.
REQ-017 READ_SHIFT: misoBufEn=1 every clk in state; WIDTH sclkPosEdge pulses counted -> DONE.
REQ-018 WRITE_SHIFT: WIDTH sclkPosEdge pulses counted -> WRITE_MEM.
REQ-019 WRITE_MEM: dataMemWrEn=1 for exactly one clk -> DONE.
REQ-020 DONE: all outputs 0; remain until chipSelect=1, then IDLE.
REQ-021 Outputs SHALL be registered Moore outputs; every enable 0 outside the states named above.
REQ-022 chipSelect=1 in any non-IDLE state SHALL force IDLE next clk, overriding any simultaneous sclkPosEdge or pending transition.
REQ-023 sclkPosEdge during GOT_ADDR, READ_LOAD, WRITE_MEM, DONE, IDLE SHALL be ignored.
REQ-024 Bit counter SHALL be $clog2(WIDTH)+1 bits wide and never wrap within a transaction.

Reset
REQ-025 reset=1 SHALL, at next clk edge, set state IDLE, counter 0, srWrEn=addrLatchEn=dataMemWrEn=misoBufEn=txnAbort=0.
REQ-026 reset SHALL take priority over chipSelect and sclkPosEdge, including mid-transaction.

Configuration
REQ-027 Macro SPI_FSM_ABORT_EN defined: txnAbort pulses 1 clk when REQ-022 fires from GET_ADDR, GOT_ADDR, READ_LOAD, READ_SHIFT, WRITE_SHIFT or WRITE_MEM (not DONE).
REQ-028 Macro SPI_FSM_ABORT_EN undefined: txnAbort port present, tied to 0; no abort logic synthesized.

Structure
REQ-029 State encoding localparams and default WIDTH SHALL live in shared package spi_pkg, also used by the shift-register bench.
REQ-030 Bit counter SHALL be a sub-module spi_bitcounter (clear, increment-enable, done-at-WIDTH output).

Verification
REQ-031 Read: CS=0, shift in 8'b1010_1011 (8 pulses) -> addrLatchEn 1 clk, srWrEn 1 clk, misoBufEn=1 for next 8 pulses, then DONE; CS=1 -> IDLE.
REQ-032 Write: CS=0, shift 8'b0101_0100 then 8 data pulses -> addrLatchEn 1 clk, misoBufEn stays 0, dataMemWrEn exactly 1 clk after 8th data pulse.
REQ-033 Abort: CS=1 after 3 address pulses -> IDLE next clk, no enables asserted, txnAbort=1 for 1 clk (only with SPI_FSM_ABORT_EN).
REQ-034 Reset mid-READ_SHIFT after 4 pulses -> all outputs 0 next clk; fresh CS=0 transaction completes normally.
REQ-035 Simultaneous CS=1 and 8th sclkPosEdge in GET_ADDR -> IDLE, addrLatchEn never asserts.
REQ-036 Extra sclkPosEdge in DONE with CS=0 -> no output change; dataMemWrEn/srWrEn remain 0.
